// File: rtl/pose_snapshot_fifo_pkg.sv
// Shared types and constants for the pose snapshot FIFO.
// Optional feature macro: POSE_FIFO_TIMESTAMP_EN adds a 32-bit capture timestamp to each entry.
package pose_snapshot_fifo_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2
    } pose_state_t;

    localparam logic [7:0] DROP_MAX = 8'd255;

`ifdef POSE_FIFO_TIMESTAMP_EN
    localparam int unsigned TSTAMP_W = 32;
`else
    localparam int unsigned TSTAMP_W = 0;
`endif

    // Stored entry: {timestamp (optional), theta, pY, pX}
    function automatic int unsigned entry_width(input int unsigned data_w);
        return 3 * data_w + TSTAMP_W;
    endfunction

endpackage

// File: rtl/pose_snapshot_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset so the head outputs read zero after reset.
module pose_fifo_mem #(
    parameter int unsigned WIDTH  = 96,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] r_rd_data;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pose_snapshot_fifo.sv
// Pose snapshot FIFO: captures {pX, pY, theta} on each enabled int_i rising edge
// (deferred while pos_busy) and presents them first-word-fall-through to a reader.
// Optional feature macro: POSE_FIFO_TIMESTAMP_EN adds rd_tstamp and a free-running cycle counter.
module pose_snapshot_fifo
    import pose_snapshot_fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  int_i,
    input  logic                  pos_busy,
    input  logic [DATA_W-1:0]     pX,
    input  logic [DATA_W-1:0]     pY,
    input  logic [DATA_W-1:0]     theta,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_pX,
    output logic [DATA_W-1:0]     rd_pY,
    output logic [DATA_W-1:0]     rd_theta,
`ifdef POSE_FIFO_TIMESTAMP_EN
    output logic [31:0]           rd_tstamp,
`endif
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned ENTRY_W = entry_width(DATA_W);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

    pose_state_t             r_state, w_state_nxt;
    logic                    r_int_q;
    logic                    w_tick, w_capt, w_full, w_pop, w_push, w_drop;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr, r_rd_ptr, w_rd_addr;
    logic [DEPTH_LOG2:0]     r_level, w_level_after_pop;
    logic                    r_rd_valid, r_overflow;
    logic [7:0]              r_drop_cnt;
    logic [ENTRY_W-1:0]      w_wr_data, w_rd_data;

    assign w_tick = int_i & ~r_int_q;

    // int_i edge-detect register
    always_ff @(posedge clk) begin
        if (rst) r_int_q <= 1'b0;
        else     r_int_q <= int_i;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state; ticks outside IDLE merge into the pending capture
    always_comb begin
        w_state_nxt = r_state;
        w_capt      = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_tick && en) w_state_nxt = S_WAIT;
            S_WAIT:  if (!pos_busy)    w_state_nxt = S_CAPT;
            S_CAPT: begin
                w_capt      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = r_rd_valid & rd_ready;
    // Pop is taken before push, so a full FIFO still accepts a capture when popping
    assign w_push = w_capt & (~w_full | w_pop);
    assign w_drop = w_capt & w_full & ~w_pop;

    assign w_level_after_pop = r_level - (w_pop ? LVL_ONE : '0);
    // Look-ahead read address so the next entry is on the outputs right after a pop
    assign w_rd_addr = w_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;

`ifdef POSE_FIFO_TIMESTAMP_EN
    logic [31:0] r_cyc;

    // Free-running cycle counter for capture timestamps
    always_ff @(posedge clk) begin
        if (rst) r_cyc <= '0;
        else     r_cyc <= r_cyc + 32'd1;
    end

    assign w_wr_data = {r_cyc, theta, pY, pX};
    assign rd_tstamp = w_rd_data[3*DATA_W +: 32];
`else
    assign w_wr_data = {theta, pY, pX};
`endif

    // Pointers, level and head-valid; rd_valid lags a push by one cycle to match the read register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level    <= w_level_after_pop + (w_push ? LVL_ONE : '0);
            r_rd_valid <= (w_level_after_pop != '0);
        end
    end

    // Sticky overflow and saturating drop counter; clear wins over a coincident drop
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    pose_fifo_mem #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign rd_valid = r_rd_valid;
    assign rd_pX    = w_rd_data[0 +: DATA_W];
    assign rd_pY    = w_rd_data[DATA_W +: DATA_W];
    assign rd_theta = w_rd_data[2*DATA_W +: DATA_W];
    assign level    = r_level;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pose_snapshot_fifo.sv
// Testbench for pose_snapshot_fifo (default build, POSE_FIFO_TIMESTAMP_EN undefined).
module tb_pose_snapshot_fifo;

    logic        clk = 1'b0;
    logic        rst, en, int_i, pos_busy, rd_ready, ovf_clr;
    logic [31:0] pX, pY, theta;
    logic        rd_valid, overflow;
    logic [31:0] rd_pX, rd_pY, rd_theta;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] t;
    } samp_t;

    samp_t       q[$];
    logic        m_ovf;
    int unsigned m_drop;

    always #5 clk = ~clk;

    pose_snapshot_fifo #(
        .DATA_W     (32),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .int_i    (int_i),
        .pos_busy (pos_busy),
        .pX       (pX),
        .pY       (pY),
        .theta    (theta),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_pX    (rd_pX),
        .rd_pY    (rd_pY),
        .rd_theta (rd_theta),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_level"}, 64'(level), 64'(q.size()));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
    endtask

    // One capture: tick, hold pos_busy for 'busy' cycles with pX=xe, then present final values.
    task automatic fire(input int unsigned busy, input logic [31:0] xe, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] t,
                        input bit pop_cap, input bit clr_cap);
        samp_t s;
        pos_busy = (busy != 0);
        pX = xe; pY = $urandom; theta = $urandom;
        int_i = 1'b1;
        step();
        int_i = 1'b0;
        repeat (busy) step();
        pos_busy = 1'b0;
        pX = x; pY = y; theta = t;
        step();
        rd_ready = pop_cap;
        ovf_clr  = clr_cap;
        if (pop_cap) begin
            check("cap_pop_valid", 64'(rd_valid), 64'd1);
            check("cap_pop_head", 64'(rd_pX), 64'(q[0].x));
        end
        step();
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        if (pop_cap && q.size() != 0) void'(q.pop_front());
        if (q.size() < 16) begin
            s.x = x; s.y = y; s.t = t;
            q.push_back(s);
        end else if (!clr_cap) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        if (clr_cap) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endtask

    task automatic drain(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            check({tag, "_valid"}, 64'(rd_valid), 64'd1);
            check({tag, "_x"}, 64'(rd_pX), 64'(q[0].x));
            check({tag, "_y"}, 64'(rd_pY), 64'(q[0].y));
            check({tag, "_t"}, 64'(rd_theta), 64'(q[0].t));
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
            void'(q.pop_front());
        end
        check({tag, "_valid_end"}, 64'(rd_valid), 64'(q.size() != 0));
        check({tag, "_level_end"}, 64'(level), 64'(q.size()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; int_i = 1'b0; pos_busy = 1'b0;
        rd_ready = 1'b0; ovf_clr = 1'b0;
        pX = '0; pY = '0; theta = '0;
        m_ovf = 1'b0; m_drop = 0;
        step(); step();
        rst = 1'b0;
        step();

        // reset state
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_px", 64'(rd_pX), 64'd0);
        check_flags("rst");

        // single capture latency and values
        fire(0, 32'd10, 32'd10, -32'sd5, 32'd90, 0, 0);
        check("t1_valid_early", 64'(rd_valid), 64'd0);
        check("t1_level", 64'(level), 64'd1);
        step();
        check("t1_valid", 64'(rd_valid), 64'd1);
        check("t1_x", 64'(rd_pX), 64'd10);
        check("t1_y", 64'(rd_pY), 64'hFFFF_FFFB);
        check("t1_t", 64'(rd_theta), 64'd90);

        // busy deferral: value at capture time is stored
        fire(50, 32'd1, 32'd7, $urandom, $urandom, 0, 0);
        check("t2_level", 64'(level), 64'd2);
        drain(2, "t2_drain");

        // fill, overflow, coincident clear, saturation
        for (int unsigned i = 0; i < 19; i++) fire(0, $urandom, $urandom, $urandom, $urandom, 0, 0);
        check_flags("t3_full");
        fire(0, $urandom, $urandom, $urandom, $urandom, 0, 1);
        check_flags("t3_clr_wins");
        for (int unsigned i = 0; i < 260; i++) fire(0, $urandom, $urandom, $urandom, $urandom, 0, 0);
        check_flags("t3_sat");
        drain(16, "t3_drain");
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        m_ovf = 1'b0; m_drop = 0;
        check_flags("t3_clr");

        // push and pop together while full
        for (int unsigned i = 0; i < 16; i++) fire($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom, 0, 0);
        step();
        fire(0, $urandom, $urandom, $urandom, $urandom, 1, 0);
        check_flags("t4_full_pp");
        step();
        drain(16, "t4_drain");

        // en=0 tick ignored; long int_i high gives a single capture
        en = 1'b0;
        int_i = 1'b1;
        step();
        int_i = 1'b0;
        repeat (5) step();
        check("t5_en0_level", 64'(level), 64'd0);
        en = 1'b1;
        pX = 32'h1234_5678; pY = 32'h8765_4321; theta = 32'h0BAD_F00D;
        int_i = 1'b1;
        repeat (20) step();
        int_i = 1'b0;
        repeat (3) step();
        q.push_back('{x: 32'h1234_5678, y: 32'h8765_4321, t: 32'h0BAD_F00D});
        check("t5_hold_level", 64'(level), 64'd1);
        drain(1, "t5_drain");

        // reset mid-wait abandons the capture and empties the FIFO
        for (int unsigned i = 0; i < 5; i++) fire(0, $urandom, $urandom, $urandom, $urandom, 0, 0);
        check("t6_level5", 64'(level), 64'd5);
        pos_busy = 1'b1;
        int_i = 1'b1;
        step();
        int_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0; m_drop = 0;
        check("t6_rst_level", 64'(level), 64'd0);
        check("t6_rst_valid", 64'(rd_valid), 64'd0);
        pos_busy = 1'b0;
        repeat (5) step();
        check("t6_no_write", 64'(level), 64'd0);
        check("t6_no_valid", 64'(rd_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
